// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// opcode encodings, latencies, counter sizing and FSM states.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int MAX_LAT  = DIV_LAT;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mdu_state_e;

    function automatic logic is_mdu(logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

    function automatic logic is_long(logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_div(logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Latencies are forced into 1..CNT_MAX so the counter cannot wrap.
    function automatic logic [CNT_W-1:0] clamp_lat(int lat);
        int v;
        v = (lat < 1) ? 1 : ((lat > CNT_MAX) ? CNT_MAX : lat);
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_latency_counter.sv
// Loadable saturating down-counter timing an in-flight MDU operation.
// Holds at zero once drained.
module mdu_latency_counter
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             at_one
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value  = cnt_q;
    assign at_one = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/stall control for the multi-cycle multiply/divide unit:
// starts operations, times them, and commits HI/LO.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_LAT,
    parameter int DIV_CYCLES  = DIV_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] op_i,
    output logic       start_o,
    output logic       hi_we_o,
    output logic       lo_we_o,
    output logic       commit_o,
    output logic       busy_o,
    output logic       stall_o
);

    localparam logic [CNT_W-1:0] MULT_V = clamp_lat(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_V  = clamp_lat(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] load_val;
    logic             at_one;

    assign load_val = is_div(op_i) ? DIV_V : MULT_V;

    mdu_latency_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_o),
        .load_val (load_val),
        .value    (cnt_val),
        .at_one   (at_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_o  = 1'b0;
        hi_we_o  = 1'b0;
        lo_we_o  = 1'b0;
        commit_o = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    start_o = is_long(op_i) && !req;
                    hi_we_o = (op_i == OP_MTHI) && !req;
                    lo_we_o = (op_i == OP_MTLO) && !req;
                    if (start_o) begin
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    commit_o = at_one;
                    // A drained counter must never leave the FSM stuck busy.
                    if (at_one || (cnt_val == '0)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q == S_BUSY);
    assign stall_o = start_o || (busy_o && is_mdu(op_i));

endmodule
